// File: rtl/o_serdes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : o_serdes_pkg
// Description : Shared types and limits for the output-direction serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package o_serdes_pkg;

    localparam int SERDES_MIN_WIDTH = 3;
    localparam int SERDES_MAX_WIDTH = 10;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } serdes_state_t;

endpackage : o_serdes_pkg
`default_nettype wire

// File: rtl/o_serdes_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : o_serdes_shift_reg
// Description : Parallel-load shifter with a registered serial output bit.
//               The first bit of a loaded word appears on o_bit at the load
//               edge; r_sr keeps only the bits still to be sent.
// Revision    : 1.0 - initial release
// ============================================================================
module o_serdes_shift_reg #(
    parameter int   DATA_WIDTH = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_shift,
    input  logic                  i_idle,
    output logic                  o_bit
);

    logic [DATA_WIDTH-1:0] r_sr;
    logic                  r_bit;

    logic                  w_load_first;
    logic [DATA_WIDTH-1:0] w_load_rest;
    logic                  w_shift_first;
    logic [DATA_WIDTH-1:0] w_shift_rest;

    // Bit ordering: MSB-first shifts left out of the top, LSB-first shifts
    // right out of the bottom.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_load_first  = i_data[DATA_WIDTH-1];
            assign w_load_rest   = {i_data[DATA_WIDTH-2:0], 1'b0};
            assign w_shift_first = r_sr[DATA_WIDTH-1];
            assign w_shift_rest  = {r_sr[DATA_WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_load_first  = i_data[0];
            assign w_load_rest   = {1'b0, i_data[DATA_WIDTH-1:1]};
            assign w_shift_first = r_sr[0];
            assign w_shift_rest  = {1'b0, r_sr[DATA_WIDTH-1:1]};
        end
    endgenerate

    // Load, shift or park the output at the idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr  <= '0;
            r_bit <= IDLE_LEVEL;
        end else if (i_load) begin
            r_sr  <= w_load_rest;
            r_bit <= w_load_first;
        end else if (i_shift) begin
            r_sr  <= w_shift_rest;
            r_bit <= w_shift_first;
        end else if (i_idle) begin
            r_sr  <= '0;
            r_bit <= IDLE_LEVEL;
        end
    end

    assign o_bit = r_bit;

endmodule : o_serdes_shift_reg
`default_nettype wire

// File: rtl/o_serdes_tx.sv
`default_nettype none
// ============================================================================
// Module      : o_serdes_tx
// Description : Double-buffered parallel-to-serial transmitter driving the
//               data and enable of an output/tristate pad. One bit per CLK,
//               gapless streaming via a single holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module o_serdes_tx
    import o_serdes_pkg::*;
#(
    parameter int   DATA_WIDTH   = 8,
    parameter bit   MSB_FIRST    = 1'b1,
    parameter logic IDLE_LEVEL   = 1'b1,
    parameter logic OE_WHEN_IDLE = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  D_VALID,
    output logic                  D_READY,
    output logic                  O,
    output logic                  OE,
    output logic                  BUSY,
    output logic                  WORD_DONE
);

    localparam int                CNT_W  = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(DATA_WIDTH - 1);

    generate
        if (DATA_WIDTH < SERDES_MIN_WIDTH || DATA_WIDTH > SERDES_MAX_WIDTH) begin : g_bad_width
            $error("o_serdes_tx: DATA_WIDTH must be within 3..10");
        end
    endgenerate

    serdes_state_t         r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_full;
    logic                  r_d_ready;
    logic                  r_oe;
    logic                  r_done;

    serdes_state_t         w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_hold_full_nxt;
    logic                  w_hold_load;
    logic                  w_sr_load;
    logic                  w_sr_from_hold;
    logic                  w_sr_shift;
    logic                  w_sr_idle;
    logic                  w_oe_nxt;
    logic                  w_done_nxt;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_sr_data;

    // Ready comes straight from a register, so a transfer never depends
    // combinationally on D_VALID feeding back into D_READY.
    assign w_xfer    = D_VALID & r_d_ready;
    assign w_sr_data = w_sr_from_hold ? r_hold : D;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control; the last-bit edge chains the next
    // word (held first, then bypass from D) so no idle bit is inserted.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_hold_full_nxt = r_hold_full;
        w_hold_load     = 1'b0;
        w_sr_load       = 1'b0;
        w_sr_from_hold  = 1'b0;
        w_sr_shift      = 1'b0;
        w_sr_idle       = 1'b0;
        w_oe_nxt        = r_oe;
        w_done_nxt      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_sr_load   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                    w_oe_nxt    = 1'b1;
                end
            end
            SHIFT: begin
                if (r_cnt == C_LAST) begin
                    w_done_nxt = 1'b1;
                    w_cnt_nxt  = '0;
                    if (r_hold_full) begin
                        w_sr_load       = 1'b1;
                        w_sr_from_hold  = 1'b1;
                        w_hold_full_nxt = 1'b0;
                    end else if (w_xfer) begin
                        w_sr_load = 1'b1;
                    end else begin
                        w_sr_idle   = 1'b1;
                        w_state_nxt = IDLE;
                        w_oe_nxt    = OE_WHEN_IDLE;
                    end
                end else begin
                    w_sr_shift = 1'b1;
                    w_cnt_nxt  = r_cnt + CNT_W'(1);
                    if (w_xfer) begin
                        w_hold_load     = 1'b1;
                        w_hold_full_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Counter, holding register, handshake and pad-enable registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt       <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_d_ready   <= 1'b1;
            r_oe        <= OE_WHEN_IDLE;
            r_done      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_d_ready   <= ~w_hold_full_nxt;
            r_oe        <= w_oe_nxt;
            r_done      <= w_done_nxt;
            if (w_hold_load) begin
                r_hold <= D;
            end
        end
    end

    o_serdes_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .MSB_FIRST  (MSB_FIRST),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_shift_reg (
        .clk     (CLK),
        .rst     (RST),
        .i_load  (w_sr_load),
        .i_data  (w_sr_data),
        .i_shift (w_sr_shift),
        .i_idle  (w_sr_idle),
        .o_bit   (O)
    );

    assign D_READY   = r_d_ready;
    assign OE        = r_oe;
    assign BUSY      = (r_state == SHIFT);
    assign WORD_DONE = r_done;

endmodule : o_serdes_tx
`default_nettype wire
